// File: rtl/pipelined_skip_subtractor_if.sv
// ---------------------------------------------------------------------------
// pipelined_skip_subtractor_if
//   Operand/result handshake bundle for pipelined_skip_subtractor.
//
//   Operand side : in_valid, in_ready, a, b, bin
//   Result side  : out_valid, out_ready, diff, bout, zero
//                  (+ ovf when SKIP_SUB_OVERFLOW_EN is defined)
//
//   Modports:
//     slave  - the subtractor (consumes operands, produces results)
//     master - the surrounding producer/consumer
//
//   Optional feature macro: SKIP_SUB_OVERFLOW_EN (adds ovf).
// ---------------------------------------------------------------------------
interface pipelined_skip_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
`ifdef SKIP_SUB_OVERFLOW_EN
    logic             ovf;
`endif

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero
`ifdef SKIP_SUB_OVERFLOW_EN
        , output ovf
`endif
    );

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero
`ifdef SKIP_SUB_OVERFLOW_EN
        , input ovf
`endif
    );
endinterface

// File: rtl/pipelined_skip_subtractor.sv
// ---------------------------------------------------------------------------
// pipelined_skip_subtractor
//   Pipelined subtractor diff = a - b - bin computed as a + ~b + ~bin using
//   carry-skip slices of BLOCK bits, one register stage per slice, behind an
//   input capture register. Latency is NSTAGE = WIDTH/BLOCK cycles from the
//   accepting edge; throughput one beat per cycle.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - pipelined_skip_subtractor_if.slave
//            in_valid/in_ready/a/b/bin    operand beat
//            out_valid/out_ready          result handshake
//            diff  (a - b - bin) mod 2^WIDTH
//            bout  borrow out (a < b + bin, unsigned)
//            zero  diff == 0
//            ovf   signed overflow (only with SKIP_SUB_OVERFLOW_EN)
//
//   Parameters: WIDTH (multiple of BLOCK), BLOCK.
//   Optional feature macro: SKIP_SUB_OVERFLOW_EN.
// ---------------------------------------------------------------------------
module pipelined_skip_subtractor #(
    parameter int WIDTH = 8,
    parameter int BLOCK = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    pipelined_skip_subtractor_if.slave    bus
);
    localparam int unsigned NSTAGE = WIDTH / BLOCK;

    // Stage k (0..NSTAGE-1) holds the operands with slices 0..k-1 already
    // resolved into dif_q[k] and the carry into slice k in c_q[k].
    // Stage NSTAGE is the output register.
    logic [NSTAGE:0]  vld_q, vld_d;
    logic [NSTAGE:0]  c_q, c_d;
    logic [WIDTH-1:0] a_q   [NSTAGE];
    logic [WIDTH-1:0] a_d   [NSTAGE];
    logic [WIDTH-1:0] nb_q  [NSTAGE];
    logic [WIDTH-1:0] nb_d  [NSTAGE];
    logic [WIDTH-1:0] dif_q [NSTAGE+1];
    logic [WIDTH-1:0] dif_d [NSTAGE+1];
    logic             zero_q, zero_d;
`ifdef SKIP_SUB_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif
    logic             stall;
    logic             adv;
    logic [BLOCK:0]   res;

    // One slice of a + ~b: ripple carry, with the skip path taken when every
    // bit propagates. Both paths agree by construction.
    function automatic logic [BLOCK:0] slice_sub(
        input logic [BLOCK-1:0] as,
        input logic [BLOCK-1:0] nbs,
        input logic             cin
    );
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] s;
        logic             c;
        p = as ^ nbs;              // a XNOR b
        s = '0;
        c = cin;
        for (int unsigned i = 0; i < BLOCK; i++) begin
            s[i] = p[i] ^ c;
            c    = (as[i] & nbs[i]) | (p[i] & c);
        end
        if (&p) begin
            c = cin;
        end
        return {c, s};
    endfunction

    always_comb begin
        res    = '0;
        stall  = vld_q[NSTAGE] & ~bus.out_ready;
        // Global hold: the whole pipe freezes while the result is stalled.
        adv    = ~stall;
        vld_d  = vld_q;
        c_d    = c_q;
        zero_d = zero_q;
`ifdef SKIP_SUB_OVERFLOW_EN
        ovf_d  = ovf_q;
`endif
        for (int unsigned k = 0; k < NSTAGE; k++) begin
            a_d[k]  = a_q[k];
            nb_d[k] = nb_q[k];
        end
        for (int unsigned k = 0; k <= NSTAGE; k++) begin
            dif_d[k] = dif_q[k];
        end

        if (adv) begin
            vld_d[0] = bus.in_valid;
            a_d[0]   = bus.a;
            nb_d[0]  = ~bus.b;
            dif_d[0] = '0;
            c_d[0]   = ~bus.bin;
            for (int unsigned k = 1; k < NSTAGE; k++) begin
                a_d[k]  = a_q[k-1];
                nb_d[k] = nb_q[k-1];
            end
            for (int unsigned k = 0; k < NSTAGE; k++) begin
                res = slice_sub(a_q[k][k*BLOCK +: BLOCK],
                                nb_q[k][k*BLOCK +: BLOCK], c_q[k]);
                vld_d[k+1] = vld_q[k];
                c_d[k+1]   = res[BLOCK];
                dif_d[k+1] = dif_q[k];
                dif_d[k+1][k*BLOCK +: BLOCK] = res[BLOCK-1:0];
            end
            zero_d = ~|dif_d[NSTAGE];
`ifdef SKIP_SUB_OVERFLOW_EN
            // Operand signs differ exactly when a msb equals the stored ~b msb.
            ovf_d  = (a_q[NSTAGE-1][WIDTH-1] == nb_q[NSTAGE-1][WIDTH-1]) &
                     (dif_d[NSTAGE][WIDTH-1] != a_q[NSTAGE-1][WIDTH-1]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            // Carries reset high so bout (= ~carry) reads 0 out of reset.
            c_q    <= '1;
            zero_q <= 1'b0;
`ifdef SKIP_SUB_OVERFLOW_EN
            ovf_q  <= 1'b0;
`endif
            for (int unsigned k = 0; k < NSTAGE; k++) begin
                a_q[k]  <= '0;
                nb_q[k] <= '0;
            end
            for (int unsigned k = 0; k <= NSTAGE; k++) begin
                dif_q[k] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            c_q    <= c_d;
            zero_q <= zero_d;
`ifdef SKIP_SUB_OVERFLOW_EN
            ovf_q  <= ovf_d;
`endif
            for (int unsigned k = 0; k < NSTAGE; k++) begin
                a_q[k]  <= a_d[k];
                nb_q[k] <= nb_d[k];
            end
            for (int unsigned k = 0; k <= NSTAGE; k++) begin
                dif_q[k] <= dif_d[k];
            end
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_q[NSTAGE];
    assign bus.diff      = dif_q[NSTAGE];
    assign bus.bout      = ~c_q[NSTAGE];
    assign bus.zero      = zero_q;
`ifdef SKIP_SUB_OVERFLOW_EN
    assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_skip_subtractor.sv
// ---------------------------------------------------------------------------
// tb_pipelined_skip_subtractor
//   Self-checking bench for pipelined_skip_subtractor (WIDTH=8, BLOCK=4).
//   Expected results come from plain arithmetic; timing expectations come
//   from a queue of in-flight beats that age by one per non-stalled cycle.
// ---------------------------------------------------------------------------
module tb_pipelined_skip_subtractor;
    localparam int W   = 8;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_skip_subtractor_if #(.WIDTH(W)) bus ();

    pipelined_skip_subtractor #(.WIDTH(W), .BLOCK(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [7:0] d;
        logic       bo;
        logic       z;
        logic       ov;
        int         age;
    } exp_t;

    exp_t       q[$];
    int         checks   = 0;
    int         failures = 0;
    logic       accepted;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_diff  = '0;
    logic       prev_bout  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic bi);
        exp_t e;
        logic [8:0] r;
        int sa, sb, sd;
        r  = {1'b0, a} - {1'b0, b} - {8'd0, bi};
        sa = $signed(a);
        sb = $signed(b);
        sd = sa - sb - int'(bi);
        e.d   = r[7:0];
        e.bo  = r[8];
        e.z   = (r[7:0] == 8'd0);
        e.ov  = (sd < -128) || (sd > 127);
        e.age = 0;
        return e;
    endfunction

    // One clock cycle: compare at the falling edge, update the model,
    // then advance to just after the next rising edge.
    task automatic step();
        logic ev, stall_m;
        exp_t f, e;
        @(negedge clk);
        ev = (q.size() > 0) && (q[0].age >= LAT);
        chk("out_valid", 32'(bus.out_valid), 32'(ev));
        if (ev) begin
            f = q[0];
            chk("diff", 32'(bus.diff), 32'(f.d));
            chk("bout", 32'(bus.bout), 32'(f.bo));
            chk("zero", 32'(bus.zero), 32'(f.z));
`ifdef SKIP_SUB_OVERFLOW_EN
            chk("ovf", 32'(bus.ovf), 32'(f.ov));
`endif
        end
        if (prev_stall) begin
            chk("hold_diff", 32'(bus.diff), 32'(prev_diff));
            chk("hold_bout", 32'(bus.bout), 32'(prev_bout));
        end
        stall_m = ev && !bus.out_ready;
        chk("in_ready", 32'(bus.in_ready), 32'(!stall_m));
        accepted = bus.in_valid && !stall_m && !rst;
        if (rst) begin
            q.delete();
        end else begin
            if (ev && bus.out_ready) void'(q.pop_front());
            if (!stall_m) begin
                for (int i = 0; i < q.size(); i++) begin
                    e = q[i];
                    e.age++;
                    q[i] = e;
                end
            end
            if (accepted) q.push_back(model(bus.a, bus.b, bus.bin));
        end
        prev_stall = stall_m && !rst;
        prev_diff  = bus.diff;
        prev_bout  = bus.bout;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bi);
        int n;
        bus.in_valid = 1'b1;
        bus.a   = a;
        bus.b   = b;
        bus.bin = bi;
        n = 0;
        accepted = 1'b0;
        while (!accepted && n < 100) begin
            step();
            n++;
        end
        chk("send_accept", 32'(accepted), 32'(1));
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() > 0 && n < 200) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(q.size()), 32'(0));
    endtask

    initial begin
        int sent, cyc;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_diff",      32'(bus.diff),      32'(0));
        chk("rst_bout",      32'(bus.bout),      32'(0));
        chk("rst_zero",      32'(bus.zero),      32'(0));
`ifdef SKIP_SUB_OVERFLOW_EN
        chk("rst_ovf",       32'(bus.ovf),       32'(0));
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Basic results
        send(8'h96, 8'h69, 1'b0);
        drain();
        send(8'h00, 8'h01, 1'b0);
        drain();

        // Skip path
        send(8'h55, 8'h55, 1'b0);
        drain();
        send(8'h55, 8'h55, 1'b1);
        drain();
        send(8'h66, 8'h66, 1'b1);
        drain();

        // Back-to-back with backpressure from cycle 3 for 3 cycles
        sent = 0;
        cyc  = 0;
        while ((sent < 4 || q.size() > 0) && cyc < 50) begin
            bus.out_ready = !(cyc >= 3 && cyc < 6);
            bus.in_valid  = (sent < 4);
            bus.a   = 8'(8'h30 + 8'(sent * 17));
            bus.b   = 8'(8'h41 - 8'(sent * 5));
            bus.bin = sent[0];
            step();
            if (accepted) sent++;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("b2b_sent", 32'(sent), 32'(4));
        chk("b2b_empty", 32'(q.size()), 32'(0));

        // Reset mid-flight
        send(8'hA0, 8'h0F, 1'b0);
        send(8'h13, 8'h37, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();
        send(8'hC3, 8'h3C, 1'b0);
        drain();

`ifdef SKIP_SUB_OVERFLOW_EN
        send(8'h80, 8'h01, 1'b0);
        send(8'h7F, 8'hFF, 1'b0);
        send(8'h10, 8'h05, 1'b0);
        drain();
`endif

        // Randomized traffic with random backpressure
        sent = 0;
        cyc  = 0;
        while (sent < 1000 && cyc < 20000) begin
            if (!bus.in_valid && $urandom_range(3) != 0) begin
                bus.in_valid = 1'b1;
                bus.a   = 8'($urandom);
                bus.b   = 8'($urandom);
                bus.bin = 1'($urandom);
            end
            bus.out_ready = ($urandom_range(9) < 7);
            step();
            if (accepted) begin
                sent++;
                bus.in_valid = 1'b0;
            end
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("rand_sent", 32'(sent), 32'(1000));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
